keypad_lock_ctrl: RTL and testbench
===================================

// Module: keypad_lock_ctrl
// PURPOSE
// - Parametrised successor of the 4-key digital lock: N-key sequence entry, programmable code, retry limit, alarm lockout.
// - Handles entry timeout and pause. Drives door-open/alarm flags and status to the 7-seg/LED and audio front ends.
// - Sits between the debounced key inputs and the display/sound blocks.
// PARAMETERS
// NUM_KEYS     4     number of keys; key index width KW = (NUM_KEYS<=2)?1:$clog2(NUM_KEYS)
// CODE_LEN     4     digits per code entry
// MAX_TRIES    3     consecutive wrong codes before alarm
// TIMEOUT_CYC  1000  idle cycles in ENTRY before the partial entry is discarded
// OPEN_CYC     2000  cycles unlocked stays high after a correct code
// LOCKOUT_CYC  5000  cycles alarm stays high; keys ignored meanwhile
// PORTS
// clk       in   1                  system clock
// reset     in   1                  synchronous, active-high reset
// keys      in   NUM_KEYS           debounced, clk-synchronous key levels (bit i = key i)
// Pause     in   1                  1 = freeze all timers; key entry still accepted
// code      in   CODE_LEN*KW        secret code; digit 0 (first entered) in [KW-1:0]; static
// unlocked  out  1                  door open
// alarm     out  1                  lockout active (feeds sound block)
// key_ack   out  1                  1-cycle pulse per accepted digit
// fail      out  1                  1-cycle pulse per wrong complete code
// digit_cnt out  clog2(CODE_LEN+1)  digits entered so far
// fail_cnt  out  clog2(MAX_TRIES+1) consecutive failures
// state     out  3                  IDLE=0 ENTRY=1 CHECK=2 OPEN=3 ALARM=4
// BEHAVIOUR
// - Reset: state=IDLE. All outputs 0. Internal prev-key register, timers and digit buffer cleared.
// - Reset mid-operation aborts any state, including OPEN and ALARM, at the next edge.
// - Press detect: press = (keys & ~keys_prev) != 0 with exactly one bit of keys high (one-hot).
//   - Multi-key chords and further edges while another key is held are ignored.
//   - Holding a key yields one press only.
// - IDLE: a press stores the digit at index 0, sets digit_cnt=1 and moves to ENTRY. key_ack is high the next cycle.
// - ENTRY: each press stores the digit at index digit_cnt and increments digit_cnt. Every press restarts the timeout timer.
//   - The press that makes digit_cnt==CODE_LEN moves to CHECK.
//   - Timer counts only when Pause=0.
//   - At TIMEOUT_CYC: digits are discarded, digit_cnt=0, state=IDLE. fail_cnt is unchanged; no fail pulse.
// - CHECK: exactly one cycle; keys ignored. The full sequence is compared, with no early rejection on the first wrong digit.
//   - Match: go to OPEN, unlocked=1, fail_cnt=0, digit_cnt=0.
//   - Mismatch: fail pulses 1 cycle, fail_cnt++ and digit_cnt=0.
//     - If the new fail_cnt==MAX_TRIES, go to ALARM with alarm=1. Otherwise go to IDLE.
// - Latency: last digit press sampled at edge N → state=CHECK after N. unlocked, or alarm/fail, goes high after edge N+1.
// - OPEN: unlocked=1 for OPEN_CYC unpaused cycles, then IDLE with unlocked=0. Presses are ignored.
// - ALARM: alarm=1 for LOCKOUT_CYC unpaused cycles. Presses are ignored and give no key_ack.
//   - On expiry: IDLE, alarm=0, fail_cnt=0.
// - Pause=1 holds every timer at its value. Pause never changes state by itself.
// - A press coinciding with timeout expiry: the timeout wins and the press is dropped.
// - Timers saturate and never wrap. fail_cnt never exceeds MAX_TRIES.
// TESTING (NUM_KEYS=4, CODE_LEN=4, TIMEOUT_CYC=20, OPEN_CYC=30, LOCKOUT_CYC=50, code digits 0,0,0,2)
// - Press key0 ×3, then key2, each as a 1-cycle pulse with gaps → 4 key_ack pulses.
//   unlocked=1 two cycles after the key2 edge, held 30 cycles, then 0. fail_cnt=0.
// - Enter 0,0,1,2 → fail pulse, fail_cnt=1, state IDLE. Then the correct code → unlocked=1, fail_cnt=0.
// - Three wrong codes → alarm=1 for exactly 50 cycles. Presses during alarm produce no key_ack.
//   Afterwards fail_cnt=0 and state=IDLE.
// - Enter 2 digits, then idle 20 cycles → digit_cnt=0, state IDLE, fail_cnt unchanged.
//   Repeat with Pause=1 for 40 cycles → no timeout until 20 unpaused cycles elapse.
// - keys=4'b0011 chord and a key held 10 cycles → no press from the chord, one press from the hold.
//   Assert reset during OPEN → unlocked=0 and state=IDLE next cycle.

Source files
------------

// File: rtl/keypad_lock_ctrl.sv
// keypad_lock_ctrl
// Programmable N-key code lock. It sits between the debounced key inputs and
// the display/sound front ends. Features: digit entry with an idle timeout, a
// one-cycle full-sequence check, a timed door-open window, and an alarm
// lockout after MAX_TRIES consecutive wrong codes. Pause freezes every timer
// but still lets digits be entered. All outputs are registered.

module keypad_lock_ctrl #(
    parameter int NUM_KEYS    = 4,
    parameter int CODE_LEN    = 4,
    parameter int MAX_TRIES   = 3,
    parameter int TIMEOUT_CYC = 1000,
    parameter int OPEN_CYC    = 2000,
    parameter int LOCKOUT_CYC = 5000,
    localparam int KW = (NUM_KEYS <= 2) ? 1 : $clog2(NUM_KEYS),
    localparam int DW = $clog2(CODE_LEN + 1),
    localparam int FW = $clog2(MAX_TRIES + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_KEYS-1:0]    keys,
    input  logic                   Pause,
    input  logic [CODE_LEN*KW-1:0] code,
    output logic                   unlocked,
    output logic                   alarm,
    output logic                   key_ack,
    output logic                   fail,
    output logic [DW-1:0]          digit_cnt,
    output logic [FW-1:0]          fail_cnt,
    output logic [2:0]             state
);

    // State encoding is visible on the status port, so keep these values fixed.
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ENTRY = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_OPEN  = 3'd3;
    localparam logic [2:0] S_ALARM = 3'd4;

    // One shared timer serves ENTRY, OPEN and ALARM. Only one of them is
    // active at a time, so it is sized for the longest of the three.
    localparam int TMAX_A = (TIMEOUT_CYC > OPEN_CYC) ? TIMEOUT_CYC : OPEN_CYC;
    localparam int TMAX   = (TMAX_A > LOCKOUT_CYC) ? TMAX_A : LOCKOUT_CYC;
    localparam int TW     = $clog2(TMAX + 1);

    // Each window ends on the edge where the timer already holds "length-1".
    // The timer therefore never has to count past its limit.
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] OPEN_LAST    = TW'(OPEN_CYC - 1);
    localparam logic [TW-1:0] LOCKOUT_LAST = TW'(LOCKOUT_CYC - 1);
    localparam logic [DW-1:0] LAST_DIGIT   = DW'(CODE_LEN - 1);
    localparam logic [FW-1:0] TRIES_LIMIT  = FW'(MAX_TRIES);

    logic [2:0]          state_reg, state_next;
    logic [TW-1:0]       timer_reg, timer_next;
    logic [DW-1:0]       digit_cnt_reg, digit_cnt_next;
    logic [FW-1:0]       fail_cnt_reg, fail_cnt_next;
    logic                unlocked_reg, unlocked_next;
    logic                alarm_reg, alarm_next;
    logic                key_ack_reg, key_ack_next;
    logic                fail_reg, fail_next;
    logic [NUM_KEYS-1:0] keys_prev_reg;

    logic                one_hot;
    logic                press;
    logic [KW-1:0]       key_idx;
    logic                store_en;
    logic [CODE_LEN-1:0] digit_ok;
    logic                code_match;
    logic [FW-1:0]       fail_cnt_inc;

    // Bit b of a key index is set for every key whose position has bit b set.
    function automatic logic [NUM_KEYS-1:0] index_mask(input int b);
        logic [NUM_KEYS-1:0] m;
        m = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            m[k] = ((k >> b) & 1) == 1;
        end
        return m;
    endfunction

    // A press needs a new rising edge while exactly one key is down.
    // This rejects chords and extra keys pressed while another is held.
    assign one_hot = (keys != '0) && ((keys & (keys - 1'b1)) == '0);
    assign press   = one_hot && ((keys & ~keys_prev_reg) != '0);

    // One-hot to binary: each index bit ORs together the keys that set it.
    genvar gi;
    generate
        for (gi = 0; gi < KW; gi++) begin : g_idx
            assign key_idx[gi] = |(keys & index_mask(gi));
        end
    endgenerate

    // Digit buffer. Each slot holds its own register and compares against its
    // own code digit, so CHECK sees the whole sequence at once.
    generate
        for (gi = 0; gi < CODE_LEN; gi++) begin : g_digit
            logic [KW-1:0] digit_reg;

            // Capture the key index when this slot is the next to fill.
            always_ff @(posedge clk) begin
                if (reset) begin
                    digit_reg <= '0;
                end else if (store_en && (digit_cnt_reg == DW'(gi))) begin
                    digit_reg <= key_idx;
                end
            end

            assign digit_ok[gi] = (digit_reg == code[gi*KW +: KW]);
        end
    endgenerate

    assign code_match = &digit_ok;

    // Saturating failure increment; the count can never pass the alarm limit.
    assign fail_cnt_inc = (fail_cnt_reg == TRIES_LIMIT) ? fail_cnt_reg
                                                        : fail_cnt_reg + 1'b1;

    // Next-state and output decode for the lock sequencer.
    always_comb begin
        state_next     = state_reg;
        timer_next     = timer_reg;
        digit_cnt_next = digit_cnt_reg;
        fail_cnt_next  = fail_cnt_reg;
        unlocked_next  = 1'b0;
        alarm_next     = 1'b0;
        key_ack_next   = 1'b0;
        fail_next      = 1'b0;
        store_en       = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (press) begin
                    store_en       = 1'b1;
                    key_ack_next   = 1'b1;
                    digit_cnt_next = digit_cnt_reg + 1'b1;
                    timer_next     = '0;
                    state_next     = (digit_cnt_reg == LAST_DIGIT) ? S_CHECK : S_ENTRY;
                end
            end

            S_ENTRY: begin
                // Timeout takes priority over a press on the same edge.
                if (!Pause && (timer_reg == TIMEOUT_LAST)) begin
                    digit_cnt_next = '0;
                    timer_next     = '0;
                    state_next     = S_IDLE;
                end else begin
                    if (!Pause) begin
                        timer_next = timer_reg + 1'b1;
                    end
                    if (press) begin
                        store_en       = 1'b1;
                        key_ack_next   = 1'b1;
                        digit_cnt_next = digit_cnt_reg + 1'b1;
                        timer_next     = '0;
                        state_next     = (digit_cnt_reg == LAST_DIGIT) ? S_CHECK : S_ENTRY;
                    end
                end
            end

            S_CHECK: begin
                digit_cnt_next = '0;
                timer_next     = '0;
                if (code_match) begin
                    unlocked_next = 1'b1;
                    fail_cnt_next = '0;
                    state_next    = S_OPEN;
                end else begin
                    fail_next     = 1'b1;
                    fail_cnt_next = fail_cnt_inc;
                    if (fail_cnt_inc == TRIES_LIMIT) begin
                        alarm_next = 1'b1;
                        state_next = S_ALARM;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end

            S_OPEN: begin
                unlocked_next = 1'b1;
                if (!Pause) begin
                    if (timer_reg == OPEN_LAST) begin
                        unlocked_next = 1'b0;
                        timer_next    = '0;
                        state_next    = S_IDLE;
                    end else begin
                        timer_next = timer_reg + 1'b1;
                    end
                end
            end

            S_ALARM: begin
                alarm_next = 1'b1;
                if (!Pause) begin
                    if (timer_reg == LOCKOUT_LAST) begin
                        alarm_next    = 1'b0;
                        fail_cnt_next = '0;
                        timer_next    = '0;
                        state_next    = S_IDLE;
                    end else begin
                        timer_next = timer_reg + 1'b1;
                    end
                end
            end

            default: begin
                digit_cnt_next = '0;
                timer_next     = '0;
                state_next     = S_IDLE;
            end
        endcase
    end

    // Register the sequencer state, counters and all outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            timer_reg     <= '0;
            digit_cnt_reg <= '0;
            fail_cnt_reg  <= '0;
            unlocked_reg  <= 1'b0;
            alarm_reg     <= 1'b0;
            key_ack_reg   <= 1'b0;
            fail_reg      <= 1'b0;
            keys_prev_reg <= '0;
        end else begin
            state_reg     <= state_next;
            timer_reg     <= timer_next;
            digit_cnt_reg <= digit_cnt_next;
            fail_cnt_reg  <= fail_cnt_next;
            unlocked_reg  <= unlocked_next;
            alarm_reg     <= alarm_next;
            key_ack_reg   <= key_ack_next;
            fail_reg      <= fail_next;
            keys_prev_reg <= keys;
        end
    end

    assign unlocked  = unlocked_reg;
    assign alarm     = alarm_reg;
    assign key_ack   = key_ack_reg;
    assign fail      = fail_reg;
    assign digit_cnt = digit_cnt_reg;
    assign fail_cnt  = fail_cnt_reg;
    assign state     = state_reg;

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// Testbench for keypad_lock_ctrl: a vector table, directed corner-case
// sequences and randomized traffic, all checked cycle by cycle against a
// behavioural lock model.
`timescale 1ns/1ps

module tb_keypad_lock_ctrl;

    localparam int NK = 4;
    localparam int CL = 4;
    localparam int MT = 3;
    localparam int TO = 20;
    localparam int OC = 30;
    localparam int LC = 50;
    // Code digits 0,0,0,2 with digit 0 in the low bits.
    localparam logic [7:0] CODE = 8'b10_00_00_00;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] keys;
    logic       Pause;
    logic       unlocked, alarm, key_ack, fail;
    logic [2:0] digit_cnt;
    logic [1:0] fail_cnt;
    logic [2:0] state;

    keypad_lock_ctrl #(
        .NUM_KEYS(NK), .CODE_LEN(CL), .MAX_TRIES(MT),
        .TIMEOUT_CYC(TO), .OPEN_CYC(OC), .LOCKOUT_CYC(LC)
    ) dut (
        .clk(clk), .reset(reset), .keys(keys), .Pause(Pause), .code(CODE),
        .unlocked(unlocked), .alarm(alarm), .key_ack(key_ack), .fail(fail),
        .digit_cnt(digit_cnt), .fail_cnt(fail_cnt), .state(state)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int ack_seen = 0;

    // ---------------- behavioural reference model ----------------
    // Mode numbers follow the status encoding: 0 idle, 1 entry, 2 check,
    // 3 open, 4 alarm. Entered digits live in a queue. Idle time counts up
    // since the last press; open/alarm windows count down the cycles left.
    int         m_state = 0;
    int         m_fails = 0;
    int         m_idle  = 0;
    int         m_left  = 0;
    int         m_digits[$];
    logic [3:0] m_prev  = '0;
    bit         m_ack   = 0;
    bit         m_fail  = 0;
    int         code_digits [4] = '{0, 0, 0, 2};

    task automatic model_step(input logic [3:0] k, input bit p, input bit r);
        bit press;
        bit expired;
        bit ok;
        int d;
        m_ack  = 0;
        m_fail = 0;
        if (r) begin
            m_state = 0; m_fails = 0; m_idle = 0; m_left = 0;
            m_digits.delete();
            m_prev = '0;
            return;
        end
        press = ($countones(k) == 1) && ((k & ~m_prev) != 0);
        d = 0;
        for (int i = 0; i < 4; i++) if (k[i]) d = i;
        m_prev = k;
        expired = 0;
        case (m_state)
            0, 1: begin
                if (m_state == 1 && !p) begin
                    m_idle++;
                    if (m_idle >= TO) expired = 1;
                end
                if (expired) begin
                    m_digits.delete();
                    m_state = 0;
                end else if (press) begin
                    m_digits.push_back(d);
                    m_ack  = 1;
                    m_idle = 0;
                    m_state = (m_digits.size() == CL) ? 2 : 1;
                end
            end
            2: begin
                ok = 1;
                for (int i = 0; i < CL; i++) if (m_digits[i] != code_digits[i]) ok = 0;
                m_digits.delete();
                if (ok) begin
                    m_state = 3; m_left = OC; m_fails = 0;
                end else begin
                    m_fail = 1;
                    m_fails++;
                    if (m_fails == MT) begin m_state = 4; m_left = LC; end
                    else m_state = 0;
                end
            end
            3: if (!p) begin
                m_left--;
                if (m_left == 0) m_state = 0;
            end
            4: if (!p) begin
                m_left--;
                if (m_left == 0) begin m_state = 0; m_fails = 0; end
            end
            default: m_state = 0;
        endcase
    endtask

    // One clock cycle: drive inputs, step the model on the edge, compare #1 later.
    task automatic cycle(input logic [3:0] k, input bit p, input bit r);
        logic [11:0] got, exp;
        keys  = k;
        Pause = p;
        reset = r;
        @(posedge clk);
        model_step(k, p, r);
        #1;
        got = {state, unlocked, alarm, key_ack, fail, digit_cnt, fail_cnt};
        exp = {3'(m_state), m_state == 3, m_state == 4, m_ack, m_fail,
               3'(m_digits.size()), 2'(m_fails)};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL model t=%0t got st/unl/alm/ack/fail/dc/fc=%b expected %b",
                     $time, got, exp);
        end
        if (key_ack === 1'b1) ack_seen++;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic idle(input int n, input bit p);
        for (int i = 0; i < n; i++) cycle(4'b0000, p, 0);
    endtask

    task automatic press_key(input int idx);
        cycle(4'(1 << idx), 0, 0);
        cycle(4'b0000, 0, 0);
    endtask

    task automatic enter4(input int d0, input int d1, input int d2, input int d3);
        press_key(d0); press_key(d1); press_key(d2); press_key(d3);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0] k;
        bit         p;
        bit         r;
        logic [2:0] st;
        bit         unl;
        bit         alm;
        bit         ack;
        bit         fl;
        logic [2:0] dc;
        logic [1:0] fc;
    } vec_t;

    vec_t tbl [17];

    // Bounded run time in case the DUT never produces an awaited event.
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_open, n_alarm, acks;
        logic [11:0] got, exp;

        keys = '0; Pause = 0; reset = 1;

        //           keys    p  r   st    unl alm ack fl dc    fc
        tbl[0]  = '{4'b0000, 0, 1, 3'd0, 0, 0, 0, 0, 3'd0, 2'd0};
        tbl[1]  = '{4'b0011, 0, 0, 3'd0, 0, 0, 0, 0, 3'd0, 2'd0}; // chord ignored
        tbl[2]  = '{4'b0000, 0, 0, 3'd0, 0, 0, 0, 0, 3'd0, 2'd0};
        tbl[3]  = '{4'b0001, 0, 0, 3'd1, 0, 0, 1, 0, 3'd1, 2'd0};
        tbl[4]  = '{4'b0001, 0, 0, 3'd1, 0, 0, 0, 0, 3'd1, 2'd0}; // held
        tbl[5]  = '{4'b0000, 0, 0, 3'd1, 0, 0, 0, 0, 3'd1, 2'd0};
        tbl[6]  = '{4'b0011, 0, 0, 3'd1, 0, 0, 0, 0, 3'd1, 2'd0}; // chord in entry
        tbl[7]  = '{4'b0000, 0, 0, 3'd1, 0, 0, 0, 0, 3'd1, 2'd0};
        tbl[8]  = '{4'b0001, 0, 0, 3'd1, 0, 0, 1, 0, 3'd2, 2'd0};
        tbl[9]  = '{4'b0000, 1, 0, 3'd1, 0, 0, 0, 0, 3'd2, 2'd0};
        tbl[10] = '{4'b0001, 1, 0, 3'd1, 0, 0, 1, 0, 3'd3, 2'd0}; // entry while paused
        tbl[11] = '{4'b0000, 0, 0, 3'd1, 0, 0, 0, 0, 3'd3, 2'd0};
        tbl[12] = '{4'b0100, 0, 0, 3'd2, 0, 0, 1, 0, 3'd4, 2'd0};
        tbl[13] = '{4'b0000, 0, 0, 3'd3, 1, 0, 0, 0, 3'd0, 2'd0};
        tbl[14] = '{4'b0000, 0, 0, 3'd3, 1, 0, 0, 0, 3'd0, 2'd0};
        tbl[15] = '{4'b0010, 0, 0, 3'd3, 1, 0, 0, 0, 3'd0, 2'd0}; // ignored in open
        tbl[16] = '{4'b0000, 0, 1, 3'd0, 0, 0, 0, 0, 3'd0, 2'd0}; // reset in open

        for (int i = 0; i < 17; i++) begin
            cycle(tbl[i].k, tbl[i].p, tbl[i].r);
            got = {state, unlocked, alarm, key_ack, fail, digit_cnt, fail_cnt};
            exp = {tbl[i].st, tbl[i].unl, tbl[i].alm, tbl[i].ack, tbl[i].fl, tbl[i].dc, tbl[i].fc};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL vec%0d got %b expected %b", i, got, exp);
            end
            $display("vec %0d keys=%b pause=%0d reset=%0d -> state=%0d dc=%0d ack=%0d unl=%0d",
                     i, tbl[i].k, tbl[i].p, tbl[i].r, state, digit_cnt, key_ack, unlocked);
        end

        // Correct code: four acks, unlocked for exactly OC cycles.
        idle(2, 0);
        ack_seen = 0;
        enter4(0, 0, 0, 2);
        check("correct_acks", ack_seen, 4);
        check("correct_unlocked", unlocked, 1);
        check("correct_fail_cnt", fail_cnt, 0);
        n_open = 1;
        for (int i = 0; i < 100 && unlocked === 1'b1; i++) begin
            cycle(4'b0000, 0, 0);
            if (unlocked === 1'b1) n_open++;
        end
        check("open_cycles", n_open, OC);
        check("open_end_state", state, 0);
        $display("seq correct_code: open_cycles=%0d", n_open);

        // Wrong code, then the right one.
        enter4(0, 0, 1, 2);
        check("wrong_fail_pulse", fail, 1);
        check("wrong_fail_cnt", fail_cnt, 1);
        check("wrong_state", state, 0);
        enter4(0, 0, 0, 2);
        check("retry_unlocked", unlocked, 1);
        check("retry_fail_cnt", fail_cnt, 0);
        idle(OC + 2, 0);
        $display("seq wrong_then_right: fail_cnt=%0d state=%0d", fail_cnt, state);

        // Three wrong codes -> alarm for LC cycles; key presses are ignored meanwhile.
        enter4(1, 1, 1, 1);
        enter4(3, 0, 0, 2);
        enter4(0, 0, 0, 3);
        check("alarm_raised", alarm, 1);
        check("alarm_fail_cnt", fail_cnt, 3);
        n_alarm = 1;
        acks = 0;
        for (int i = 0; i < 120 && alarm === 1'b1; i++) begin
            cycle((i % 2 == 0) ? 4'b0010 : 4'b0000, 0, 0);
            if (key_ack === 1'b1) acks++;
            if (alarm === 1'b1) n_alarm++;
        end
        check("alarm_cycles", n_alarm, LC);
        check("alarm_no_ack", acks, 0);
        check("alarm_end_fail_cnt", fail_cnt, 0);
        check("alarm_end_state", state, 0);
        idle(2, 0);
        $display("seq alarm: alarm_cycles=%0d acks=%0d", n_alarm, acks);

        // Timeout discards the partial entry and leaves fail_cnt alone.
        enter4(1, 0, 0, 2);
        press_key(1); press_key(3);
        idle(18, 0);
        check("timeout_before_state", state, 1);
        check("timeout_before_dc", digit_cnt, 2);
        idle(1, 0);
        check("timeout_state", state, 0);
        check("timeout_dc", digit_cnt, 0);
        check("timeout_fail_cnt", fail_cnt, 1);
        $display("seq timeout: state=%0d dc=%0d fail_cnt=%0d", state, digit_cnt, fail_cnt);

        // Pause holds the timeout timer.
        press_key(1); press_key(3);
        idle(40, 1);
        check("pause_state", state, 1);
        check("pause_dc", digit_cnt, 2);
        idle(18, 0);
        check("pause_before_state", state, 1);
        idle(1, 0);
        check("pause_timeout_state", state, 0);
        check("pause_timeout_fail_cnt", fail_cnt, 1);
        $display("seq pause_timeout: state=%0d", state);

        // A press landing on the timeout edge is dropped.
        press_key(2);
        idle(18, 0);
        cycle(4'b0001, 0, 0);
        check("tie_state", state, 0);
        check("tie_dc", digit_cnt, 0);
        check("tie_ack", key_ack, 0);
        idle(1, 0);
        $display("seq timeout_vs_press: state=%0d ack=%0d", state, key_ack);

        // A key held for 10 cycles gives one press.
        ack_seen = 0;
        for (int i = 0; i < 10; i++) cycle(4'b1000, 0, 0);
        cycle(4'b0000, 0, 0);
        check("hold_acks", ack_seen, 1);
        check("hold_dc", digit_cnt, 1);
        $display("seq hold: acks=%0d dc=%0d", ack_seen, digit_cnt);

        // Reset during OPEN.
        cycle(4'b0000, 0, 1);
        enter4(0, 0, 0, 2);
        check("rst_open_pre", unlocked, 1);
        cycle(4'b0000, 0, 1);
        check("rst_open_unlocked", unlocked, 0);
        check("rst_open_state", state, 0);
        $display("seq reset_in_open: unlocked=%0d state=%0d", unlocked, state);

        // Randomized traffic, checked every cycle against the model.
        for (int t = 0; t < 60; t++) begin
            int kind, nd, gap, d;
            logic [3:0] gk;
            bit gp;
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                cycle(4'b0000, 0, 1);
            end else if (kind <= 7) begin
                nd = (kind <= 3) ? 4 : $urandom_range(1, 4);
                for (int j = 0; j < nd; j++) begin
                    d = (kind <= 3) ? code_digits[j] : $urandom_range(0, 3);
                    cycle(4'(1 << d), ($urandom_range(0, 4) == 0), 0);
                    gap = $urandom_range(1, 3);
                    for (int g = 0; g < gap; g++) begin
                        gk = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
                        gp = ($urandom_range(0, 4) == 0);
                        cycle(gk, gp, 0);
                    end
                end
            end else begin
                idle($urandom_range(5, 60), ($urandom_range(0, 2) == 0));
            end
            $display("rand %0d kind=%0d state=%0d dc=%0d fail_cnt=%0d unl=%0d alarm=%0d",
                     t, kind, state, digit_cnt, fail_cnt, unlocked, alarm);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
